// File: rtl/fe_invert_core.sv
// GF(2^255-19) inverse z^(p-2) via the ref10 chain: 254 squarings + 11 multiplies on an external multiplier.
// Latency: 265 x (issue + multiplier latency + capture) + 1; waits on mul_done, one request in flight.
module fe_invert_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] z,
  output logic [319:0] out,
  input  logic         valid,
  output logic         done,
  output logic [319:0] mul_op_a,
  output logic [319:0] mul_op_b,
  output logic         mul_valid,
  input  logic [319:0] mul_res,
  input  logic         mul_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
  typedef enum logic [2:0] {R_ZR, R_T0, R_T1, R_T2, R_T3} reg_sel_t;

  localparam logic [4:0] LAST_STEP = 5'd21;

  state_t       state, state_n;
  logic [319:0] zr, t0, t1, t2, t3;
  logic [4:0]   step;
  logic [6:0]   rep;

  logic         op_sq;
  logic [6:0]   op_n;
  reg_sel_t     op_a, op_b, op_dst;
  reg_sel_t     sel_a, sel_b;
  logic         last_rep, last_step, capture;

  function automatic logic [319:0] reg_mux(input reg_sel_t s, input logic [319:0] r_zr,
                                           input logic [319:0] r_t0, input logic [319:0] r_t1,
                                           input logic [319:0] r_t2, input logic [319:0] r_t3);
    logic [319:0] v;
    v = r_zr;
    unique case (s)
      R_ZR:    v = r_zr;
      R_T0:    v = r_t0;
      R_T1:    v = r_t1;
      R_T2:    v = r_t2;
      R_T3:    v = r_t3;
      default: v = r_zr;
    endcase
    return v;
  endfunction

  // Addition chain: squaring runs use op_a as source, op_dst as destination and later source.
  always_comb begin
    op_sq  = 1'b0;
    op_n   = 7'd1;
    op_a   = R_ZR;
    op_b   = R_ZR;
    op_dst = R_T0;
    unique case (step)
      5'd0:  begin op_sq = 1'b1; op_n = 7'd1;   op_a = R_ZR; op_dst = R_T0; end
      5'd1:  begin op_sq = 1'b1; op_n = 7'd2;   op_a = R_T0; op_dst = R_T1; end
      5'd2:  begin op_a = R_ZR; op_b = R_T1; op_dst = R_T1; end
      5'd3:  begin op_a = R_T0; op_b = R_T1; op_dst = R_T0; end
      5'd4:  begin op_sq = 1'b1; op_n = 7'd1;   op_a = R_T0; op_dst = R_T2; end
      5'd5:  begin op_a = R_T1; op_b = R_T2; op_dst = R_T1; end
      5'd6:  begin op_sq = 1'b1; op_n = 7'd5;   op_a = R_T1; op_dst = R_T2; end
      5'd7:  begin op_a = R_T2; op_b = R_T1; op_dst = R_T1; end
      5'd8:  begin op_sq = 1'b1; op_n = 7'd10;  op_a = R_T1; op_dst = R_T2; end
      5'd9:  begin op_a = R_T2; op_b = R_T1; op_dst = R_T2; end
      5'd10: begin op_sq = 1'b1; op_n = 7'd20;  op_a = R_T2; op_dst = R_T3; end
      5'd11: begin op_a = R_T3; op_b = R_T2; op_dst = R_T2; end
      5'd12: begin op_sq = 1'b1; op_n = 7'd10;  op_a = R_T2; op_dst = R_T2; end
      5'd13: begin op_a = R_T2; op_b = R_T1; op_dst = R_T1; end
      5'd14: begin op_sq = 1'b1; op_n = 7'd50;  op_a = R_T1; op_dst = R_T2; end
      5'd15: begin op_a = R_T2; op_b = R_T1; op_dst = R_T2; end
      5'd16: begin op_sq = 1'b1; op_n = 7'd100; op_a = R_T2; op_dst = R_T3; end
      5'd17: begin op_a = R_T3; op_b = R_T2; op_dst = R_T2; end
      5'd18: begin op_sq = 1'b1; op_n = 7'd50;  op_a = R_T2; op_dst = R_T2; end
      5'd19: begin op_a = R_T2; op_b = R_T1; op_dst = R_T1; end
      5'd20: begin op_sq = 1'b1; op_n = 7'd5;   op_a = R_T1; op_dst = R_T1; end
      5'd21: begin op_a = R_T1; op_b = R_T0; op_dst = R_T1; end
      default: ;
    endcase
  end

  always_comb begin
    sel_a = op_a;
    sel_b = op_b;
    if (op_sq) begin
      sel_a = (rep == 7'd0) ? op_a : op_dst;
      sel_b = sel_a;
    end
  end

  assign last_rep  = !op_sq || (rep == op_n - 7'd1);
  assign last_step = (step == LAST_STEP);
  // A product cannot arrive in the cycle its request is presented; that gates off stale pulses.
  assign capture   = (state == WAIT) && mul_done && !mul_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE:  if (valid) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (capture) state_n = (last_step && last_rep) ? FIN : ISSUE;
      FIN:   begin done = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      mul_op_a  <= '0;
      mul_op_b  <= '0;
      mul_valid <= 1'b0;
      zr        <= '0;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      step      <= '0;
      rep       <= '0;
    end else begin
      mul_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            zr   <= z;
            step <= '0;
            rep  <= '0;
          end
        end
        ISSUE: begin
          mul_op_a  <= reg_mux(sel_a, zr, t0, t1, t2, t3);
          mul_op_b  <= reg_mux(sel_b, zr, t0, t1, t2, t3);
          mul_valid <= 1'b1;
        end
        WAIT: begin
          if (capture) begin
            if (last_step) begin
              out <= mul_res;
            end else begin
              unique case (op_dst)
                R_T0:    t0 <= mul_res;
                R_T1:    t1 <= mul_res;
                R_T2:    t2 <= mul_res;
                R_T3:    t3 <= mul_res;
                default: ;
              endcase
            end
            if (last_rep) begin
              rep  <= '0;
              step <= step + 5'd1;
            end else begin
              rep <= rep + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_invert_core.sv
// Bench for fe_invert_core: exact mod-p multiplier stub with random latency, checked against modular exponentiation.
module tb_fe_invert_core;

  typedef logic [511:0] big_t;
  localparam big_t PB = (big_t'(1) << 255) - big_t'(19);
  localparam logic [319:0] Z2   = 320'h00053a81017f6f0affc217b7fe20238d008e7c68fe44054e0062a67b00a68f5600a2a82fffd1a58d;
  localparam logic [319:0] OUT2 = 320'h00a7d731ff3e2b82ffb1b4c001737c3dff6b2a2801b99e9b00e91fa401bc825bff022266ff9caf02;

  logic         clk = 1'b0;
  logic         rst, valid, done, mul_valid, mul_done;
  logic [319:0] z_in, out, mul_op_a, mul_op_b, mul_res;

  int n_asrt = 0, n_fail = 0;
  int n_req = 0, n_sq = 0, n_done = 0, n_wide = 0, n_unstable = 0;
  int last_sq;
  logic [319:0] last_out;

  fe_invert_core dut (
    .clk(clk), .rst(rst), .z(z_in), .out(out), .valid(valid), .done(done),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_valid(mul_valid),
    .mul_res(mul_res), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  function automatic big_t mulmod(input big_t a, input big_t b);
    big_t p;
    p = a * b;
    return p % PB;
  endfunction

  function automatic big_t powmod(input big_t a);
    big_t e, r;
    e = PB - big_t'(2);
    r = big_t'(1);
    for (int i = 254; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, a);
    end
    return r;
  endfunction

  // Signed limbs at offsets 0,26,51,...,230 -> integer in [0,p).
  function automatic big_t fe_to_int(input logic [319:0] f);
    logic signed [511:0] acc, l;
    int off;
    acc = '0;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      l   = {{480{f[32*i+31]}}, f[32*i +: 32]};
      acc = acc + (l <<< off);
      off = off + ((i % 2 == 0) ? 26 : 25);
    end
    acc = acc + (PB << 64);
    return big_t'(acc) % PB;
  endfunction

  function automatic logic [319:0] int_to_fe(input big_t v);
    logic [319:0] f;
    int off;
    f   = '0;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      f[32*i +: 32] = 32'(v >> off) & ((i % 2 == 0) ? 32'h03ff_ffff : 32'h01ff_ffff);
      off = off + ((i % 2 == 0) ? 26 : 25);
    end
    return f;
  endfunction

  function automatic logic [319:0] rand_fe();
    logic [319:0] f;
    int l;
    for (int i = 0; i < 10; i++) begin
      l = int'($urandom_range(0, 67108863)) - 33554432;
      f[32*i +: 32] = l;
    end
    return f;
  endfunction

  // Multiplier stub: one request at a time, random latency 1..4, tracks operand stability.
  logic [319:0] cap_a, cap_b;
  int  lat_cnt;
  bit  busy = 1'b0, aborted = 1'b0;
  initial begin
    mul_done = 1'b0;
    mul_res  = '0;
  end
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (rst && busy) aborted = 1'b1;
    if (busy) begin
      if (!aborted && !rst && (mul_op_a !== cap_a || mul_op_b !== cap_b || mul_valid)) n_unstable++;
      if (lat_cnt <= 1) begin
        mul_done <= 1'b1;
        mul_res  <= int_to_fe(mulmod(fe_to_int(cap_a), fe_to_int(cap_b)));
        busy     = 1'b0;
        aborted  = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (mul_valid && !rst) begin
      cap_a   = mul_op_a;
      cap_b   = mul_op_b;
      lat_cnt = int'($urandom_range(1, 4));
      busy    = 1'b1;
      n_req++;
      if (mul_op_a === mul_op_b) n_sq++;
    end
  end

  logic done_q = 1'b0;
  always @(posedge clk) begin
    if (done) n_done++;
    if (done && done_q) n_wide++;
    done_q <= done;
  end

  task automatic chk(input string tag, input big_t obs, input big_t exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_inv(input logic [319:0] zv, input bit poke, input string tag);
    int v0, s0, d0, w0, u0;
    bit seen;
    v0 = n_req; s0 = n_sq; d0 = n_done; w0 = n_wide; u0 = n_unstable;
    @(negedge clk);
    z_in = zv; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; z_in = '0;
    if (poke) begin
      repeat (300) @(negedge clk);
      z_in = rand_fe(); valid = 1'b1;
      @(negedge clk);
      valid = 1'b0; z_in = '0;
    end
    seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, big_t'(seen), big_t'(1));
    last_out = out;
    if (poke) begin
      z_in = rand_fe(); valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0; z_in = '0;
    repeat (4) @(negedge clk);
    last_sq = n_sq - s0;
    chk({tag, "_req_count"}, big_t'(n_req - v0), big_t'(265));
    chk({tag, "_done_count"}, big_t'(n_done - d0), big_t'(1));
    chk({tag, "_done_width"}, big_t'(n_wide - w0), big_t'(0));
    chk({tag, "_opnd_stable"}, big_t'(n_unstable - u0), big_t'(0));
    chk({tag, "_out_held"}, big_t'(out), big_t'(last_out));
  endtask

  initial begin
    logic [319:0] zr_v, zp;
    int v0, d0;
    rst = 1'b1; valid = 1'b0; z_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", big_t'(out), '0);
    chk("rst_done", big_t'(done), '0);
    chk("rst_mul_valid", big_t'(mul_valid), '0);
    chk("rst_op_a", big_t'(mul_op_a), '0);
    chk("rst_op_b", big_t'(mul_op_b), '0);
    rst = 1'b0;

    run_inv(Z2, 1'b0, "vec2");
    chk("vec2_golden", fe_to_int(last_out), fe_to_int(OUT2));
    chk("vec2_model", fe_to_int(last_out), powmod(fe_to_int(Z2)));
    chk("vec2_squarings", big_t'(last_sq), big_t'(254));

    run_inv(320'h1, 1'b0, "one");
    chk("one_out", big_t'(last_out), big_t'(1));
    run_inv('0, 1'b0, "zero");
    chk("zero_out", big_t'(last_out), '0);

    for (int k = 0; k < 3; k++) begin
      zr_v = rand_fe();
      run_inv(zr_v, 1'b0, "rand");
      chk("rand_model", fe_to_int(last_out), powmod(fe_to_int(zr_v)));
      chk("rand_inverse", mulmod(fe_to_int(last_out), fe_to_int(zr_v)), big_t'(1));
      chk("rand_squarings", big_t'(last_sq), big_t'(254));
    end

    zp = rand_fe();
    run_inv(zp, 1'b1, "poke");
    chk("poke_model", fe_to_int(last_out), powmod(fe_to_int(zp)));

    v0 = n_req; d0 = n_done;
    @(negedge clk);
    z_in = Z2; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; z_in = '0;
    for (int c = 0; c < 3000 && (n_req - v0) < 100; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mul_valid", big_t'(mul_valid), '0);
    chk("abort_done", big_t'(done), '0);
    chk("abort_out", big_t'(out), '0);
    chk("abort_op_a", big_t'(mul_op_a), '0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", big_t'(n_done - d0), '0);
    chk("abort_no_req", big_t'(mul_valid), '0);
    run_inv(Z2, 1'b0, "post_rst");
    chk("post_rst_golden", fe_to_int(last_out), fe_to_int(OUT2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
